// File: rtl/usqr_iter.sv
// Iterative unsigned fixed-point squarer with valid/ready handshake.
// Consumes BPC multiplier bits per cycle; optional round-half-up and saturation.
module usqr_iter #(
    parameter int WIDTH = 32,
    parameter int SCALE = 16,
    parameter int BPC   = 1,
    parameter int ROUND = 0,
    parameter int SAT   = 1,
    parameter int TAGW  = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [TAGW-1:0]  in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] f,
    output logic [TAGW-1:0]  out_tag,
    output logic             ovf
);

    localparam int ITER = WIDTH / BPC;
    localparam int CW   = $clog2(ITER + 1);
    localparam int SW   = $clog2(2 * WIDTH + 1);
    localparam int RSH  = (SCALE > 0) ? SCALE - 1 : 0;
    localparam logic [2*WIDTH:0] RND =
        (ROUND != 0 && SCALE > 0) ? ((2*WIDTH+1)'(1) << RSH) : '0;

    generate
        if (WIDTH % BPC != 0) begin : g_bad_bpc
            $error("usqr_iter: WIDTH must be a multiple of BPC");
        end
    endgenerate

    typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

    state_t              r_state;
    logic [WIDTH-1:0]    r_mcand;
    logic [WIDTH-1:0]    r_mplier;
    logic [2*WIDTH-1:0]  r_acc;
    logic [CW-1:0]       r_count;
    logic [TAGW-1:0]     r_tag;
    logic [WIDTH-1:0]    r_f;
    logic                r_ovf;
    logic [TAGW-1:0]     r_out_tag;
    logic                r_out_valid;
    logic                r_in_ready;

    logic [CW-1:0]       w_step;
    logic [SW-1:0]       w_shamt;
    logic [2*WIDTH-1:0]  w_pp;
    logic [2*WIDTH-1:0]  w_pp_sh;
    logic [2*WIDTH-1:0]  w_fin;
    logic [2*WIDTH:0]    w_rnd;
    logic [2*WIDTH:0]    w_r;
    logic                w_ovf;
    logic [WIDTH-1:0]    w_f;

    // Partial product of the multiplicand with the next BPC multiplier bits,
    // placed at the bit position of the digit being consumed this cycle.
    assign w_step  = CW'(ITER) - r_count;
    assign w_shamt = SW'(w_step * BPC);
    assign w_pp    = {{WIDTH{1'b0}}, r_mcand} *
                     {{(2*WIDTH-BPC){1'b0}}, r_mplier[BPC-1:0]};
    assign w_pp_sh = w_pp << w_shamt;
    assign w_fin   = r_acc + w_pp_sh;

    // One extra bit so the rounding carry is never lost before the overflow test.
    assign w_rnd = {1'b0, w_fin} + RND;
    assign w_r   = w_rnd >> SCALE;
    assign w_ovf = |w_r[2*WIDTH:WIDTH];
    assign w_f   = (w_ovf && SAT != 0) ? {WIDTH{1'b1}} : w_r[WIDTH-1:0];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_mcand     <= '0;
            r_mplier    <= '0;
            r_acc       <= '0;
            r_count     <= '0;
            r_tag       <= '0;
            r_f         <= '0;
            r_ovf       <= 1'b0;
            r_out_tag   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_mcand    <= a;
                        r_mplier   <= a;
                        r_tag      <= in_tag;
                        r_acc      <= '0;
                        r_count    <= CW'(ITER);
                        r_in_ready <= 1'b0;
                        r_state    <= S_CALC;
                    end
                end
                S_CALC: begin
                    r_acc    <= w_fin;
                    r_mplier <= r_mplier >> BPC;
                    r_count  <= r_count - CW'(1);
                    if (r_count == CW'(1)) begin
                        r_f         <= w_f;
                        r_ovf       <= w_ovf;
                        r_out_tag   <= r_tag;
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result held until the consumer takes it; in_valid is ignored here.
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign f         = r_f;
    assign ovf       = r_ovf;
    assign out_tag   = r_out_tag;

endmodule

// File: tb/tb_usqr_iter.sv
// Directed bench for usqr_iter: three configurations sharing operand/tag buses,
// expected results hand-computed for WIDTH=16, SCALE=8.
module tb_usqr_iter;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic [15:0]      a_in = '0;
    logic [3:0]       tag_in = '0;
    logic [2:0]       iv = '0;
    logic [2:0]       ordy = '0;
    logic [2:0]       irdy;
    logic [2:0]       ov;
    logic [2:0]       ovf;
    logic [2:0][15:0] fo;
    logic [2:0][3:0]  to;

    int n_chk = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    // d0: BPC=1 truncate saturate (ITER=16)
    usqr_iter #(.WIDTH(16), .SCALE(8), .BPC(1), .ROUND(0), .SAT(1), .TAGW(4)) d0 (
        .clk(clk), .reset(reset), .in_valid(iv[0]), .in_ready(irdy[0]), .a(a_in),
        .in_tag(tag_in), .out_valid(ov[0]), .out_ready(ordy[0]), .f(fo[0]),
        .out_tag(to[0]), .ovf(ovf[0]));

    // d1: BPC=4 round wrap (ITER=4)
    usqr_iter #(.WIDTH(16), .SCALE(8), .BPC(4), .ROUND(1), .SAT(0), .TAGW(4)) d1 (
        .clk(clk), .reset(reset), .in_valid(iv[1]), .in_ready(irdy[1]), .a(a_in),
        .in_tag(tag_in), .out_valid(ov[1]), .out_ready(ordy[1]), .f(fo[1]),
        .out_tag(to[1]), .ovf(ovf[1]));

    // d2: BPC=16 round saturate (ITER=1)
    usqr_iter #(.WIDTH(16), .SCALE(8), .BPC(16), .ROUND(1), .SAT(1), .TAGW(4)) d2 (
        .clk(clk), .reset(reset), .in_valid(iv[2]), .in_ready(irdy[2]), .a(a_in),
        .in_tag(tag_in), .out_valid(ov[2]), .out_ready(ordy[2]), .f(fo[2]),
        .out_tag(to[2]), .ovf(ovf[2]));

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    task automatic issue(input int k, input logic [15:0] av, input logic [3:0] tv);
        @(negedge clk);
        a_in   = av;
        tag_in = tv;
        chk("in_ready_idle", {31'd0, irdy[k]}, 32'd1);
        iv[k] = 1'b1;
        @(posedge clk);
        #1 iv[k] = 1'b0;
    endtask

    task automatic wait_done(input int k, input int lat);
        int n;
        n = 0;
        while (!ov[k] && n < 40) begin
            @(posedge clk);
            #1 n++;
        end
        chk("latency", n, lat);
    endtask

    task automatic release_out(input int k);
        @(negedge clk);
        ordy[k] = 1'b1;
        @(posedge clk);
        #1 ordy[k] = 1'b0;
        chk("out_valid_drop", {31'd0, ov[k]}, 32'd0);
        chk("in_ready_back", {31'd0, irdy[k]}, 32'd1);
    endtask

    task automatic run(input int k, input logic [15:0] av, input logic [3:0] tv,
                       input logic [15:0] ef, input logic eo, input int lat);
        issue(k, av, tv);
        wait_done(k, lat);
        chk("f", {16'd0, fo[k]}, {16'd0, ef});
        chk("ovf", {31'd0, ovf[k]}, {31'd0, eo});
        chk("out_tag", {28'd0, to[k]}, {28'd0, tv});
        release_out(k);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_in_ready", {31'd0, irdy[k]}, 32'd1);
            chk("rst_out_valid", {31'd0, ov[k]}, 32'd0);
            chk("rst_f", {16'd0, fo[k]}, 32'd0);
        end
        @(negedge clk);
        reset = 1'b0;

        // d0: truncate, saturate, 16 cycles
        run(0, 16'h0180, 4'd5, 16'h0240, 1'b0, 16);
        run(0, 16'h1000, 4'd1, 16'hFFFF, 1'b1, 16);
        run(0, 16'h000C, 4'd2, 16'h0000, 1'b0, 16);
        run(0, 16'h0000, 4'd3, 16'h0000, 1'b0, 16);
        run(0, 16'h00FF, 4'd4, 16'h00FE, 1'b0, 16);
        run(0, 16'hFFFF, 4'd6, 16'hFFFF, 1'b1, 16);

        // d1: round-half-up, wrap, 4 cycles
        run(1, 16'h1000, 4'd7, 16'h0000, 1'b1, 4);
        run(1, 16'h000C, 4'd8, 16'h0001, 1'b0, 4);
        run(1, 16'h0001, 4'd9, 16'h0000, 1'b0, 4);
        run(1, 16'hFFFF, 4'hA, 16'hFE00, 1'b1, 4);
        run(1, 16'h0B50, 4'hB, 16'h7FF9, 1'b0, 4);
        run(1, 16'h00FF, 4'hC, 16'h00FE, 1'b0, 4);

        // d2: single-cycle digit
        run(2, 16'hFFFF, 4'hD, 16'hFFFF, 1'b1, 1);
        run(2, 16'h0180, 4'hE, 16'h0240, 1'b0, 1);
        run(2, 16'h000C, 4'hF, 16'h0001, 1'b0, 1);

        // Backpressure: hold DONE while pulsing in_valid with a different operand
        issue(0, 16'h0180, 4'd9);
        wait_done(0, 16);
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            a_in   = 16'hAAAA;
            tag_in = 4'd3;
            iv[0]  = ~iv[0];
            @(posedge clk);
            #1;
            chk("bp_f", {16'd0, fo[0]}, 32'h0240);
            chk("bp_tag", {28'd0, to[0]}, 32'd9);
            chk("bp_in_ready", {31'd0, irdy[0]}, 32'd0);
            chk("bp_out_valid", {31'd0, ov[0]}, 32'd1);
        end
        @(negedge clk);
        iv[0] = 1'b0;
        release_out(0);
        @(posedge clk);
        #1 chk("bp_no_capture", {31'd0, ov[0]}, 32'd0);
        chk("bp_idle", {31'd0, irdy[0]}, 32'd1);

        // Reset mid-CALC discards the in-flight result
        issue(0, 16'h1234, 4'd7);
        repeat (7) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_out_valid", {31'd0, ov[0]}, 32'd0);
        chk("mid_rst_in_ready", {31'd0, irdy[0]}, 32'd1);
        chk("mid_rst_f", {16'd0, fo[0]}, 32'd0);
        chk("mid_rst_tag", {28'd0, to[0]}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        run(0, 16'h0200, 4'd2, 16'h0400, 1'b0, 16);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
